// File: rtl/prog_load_ctrl_pkg.sv
// Shared types for the Open8 program loader: FSM states, error codes and
// the state classification helper used by the controller.
package prog_load_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_RELEASE,
    ST_ERROR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ABORT   = 2'd3
  } err_e;

  // States in which the loader is consuming bytes from the UART.
  function automatic logic is_rx_state(state_e s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/prog_load_ctrl_if.sv
// Byte stream from the UART receiver plus the shared program-RAM port
// (CPU side in, muxed RAM side out).
interface prog_load_ctrl_if #(
  parameter int unsigned ADDR_W = 12
) ();

  logic [7:0]        i_rx_data;
  logic              i_rx_valid;
  logic              o_rx_ready;
  logic [ADDR_W-1:0] i_cpu_addr;
  logic [7:0]        i_cpu_wdata;
  logic              i_cpu_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [7:0]        o_mem_wdata;
  logic              o_mem_we;

  modport master (
    output i_rx_data, i_rx_valid, i_cpu_addr, i_cpu_wdata, i_cpu_we,
    input  o_rx_ready, o_mem_addr, o_mem_wdata, o_mem_we
  );

  modport slave (
    input  i_rx_data, i_rx_valid, i_cpu_addr, i_cpu_wdata, i_cpu_we,
    output o_rx_ready, o_mem_addr, o_mem_wdata, o_mem_we
  );

endinterface

// File: rtl/prog_load_ctrl_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module prog_load_ctrl_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/prog_load_ctrl.sv
// Program download sequencer: parses a length/payload/checksum frame from the
// UART, writes the payload into program RAM and releases the CPU on success.
module prog_load_ctrl
  import prog_load_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned REL_DLY     = 4,
  parameter int unsigned HOLD_ON_RST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  prog_load_ctrl_if.slave       bus,
  output logic                  o_cpu_rst_n,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [1:0]            o_err
);

  localparam int unsigned TMR_MAX = (TIMEOUT_CYC > REL_DLY) ? TIMEOUT_CYC : REL_DLY;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TO_LOAD = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] RD_LOAD = TMR_W'(REL_DLY - 1);
  localparam logic [63:0]      MAX_LEN = (64'd1 << ADDR_W) - 64'(BASE_ADDR);

  state_e            state_q, state_d;
  err_e              err_q, err_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       count_q, count_d;
  logic [7:0]        sum_q, sum_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ld_we_q, ld_we_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [7:0]        ld_data_q, ld_data_d;

  logic              rx_ready;
  logic              hs;
  logic [7:0]        rx_byte;
  logic [15:0]       new_len;
  logic              tmr_load;
  logic              tmr_dec;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_exp;

  assign rx_ready = is_rx_state(state_q);
  assign hs       = bus.i_rx_valid & rx_ready;
  assign rx_byte  = bus.i_rx_data;
  assign new_len  = {rx_byte, len_lo_q};

  // One timer serves both the inter-byte timeout and the release delay;
  // the two uses never overlap because RELEASE is not a receive state.
  prog_load_ctrl_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .expired  (tmr_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    count_d     = count_q;
    sum_d       = sum_q;
    cpu_rst_n_d = cpu_rst_n_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ld_we_d     = 1'b0;
    ld_addr_d   = ld_addr_q;
    ld_data_d   = ld_data_q;
    tmr_load    = 1'b0;
    tmr_val     = TO_LOAD;
    tmr_dec     = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (i_start) begin
          state_d     = ST_LEN_LO;
          cpu_rst_n_d = 1'b0;
          busy_d      = 1'b1;
          err_d       = ERR_NONE;
          count_d     = '0;
          sum_d       = '0;
          tmr_load    = 1'b1;
        end else if ((state_q == ST_IDLE) && (HOLD_ON_RST == 0)) begin
          cpu_rst_n_d = 1'b1;
        end
      end

      default: begin
        if (i_abort) begin
          state_d = ST_ERROR;
          err_d   = ERR_ABORT;
          busy_d  = 1'b0;
        end else if (state_q == ST_RELEASE) begin
          if (tmr_exp) begin
            state_d     = ST_IDLE;
            cpu_rst_n_d = 1'b1;
            done_d      = 1'b1;
            busy_d      = 1'b0;
          end else begin
            tmr_dec = 1'b1;
          end
        end else if (!hs) begin
          if (tmr_exp) begin
            state_d = ST_ERROR;
            err_d   = ERR_TIMEOUT;
            busy_d  = 1'b0;
          end else begin
            tmr_dec = 1'b1;
          end
        end else begin
          tmr_load = 1'b1;
          case (state_q)
            ST_LEN_LO: begin
              len_lo_d = rx_byte;
              state_d  = ST_LEN_HI;
            end
            ST_LEN_HI: begin
              len_d = new_len;
              if (new_len == 16'd0) begin
                state_d = ST_CSUM;
              end else if (64'(new_len) > MAX_LEN) begin
                state_d = ST_ERROR;
                err_d   = ERR_ABORT;
                busy_d  = 1'b0;
              end else begin
                state_d = ST_DATA;
              end
            end
            ST_DATA: begin
              ld_we_d   = 1'b1;
              ld_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(count_q);
              ld_data_d = rx_byte;
              sum_d     = sum_q + rx_byte;
              count_d   = count_q + 16'd1;
              if (count_q == (len_q - 16'd1)) begin
                state_d = ST_CSUM;
              end
            end
            ST_CSUM: begin
              if (rx_byte == sum_q) begin
                state_d = ST_RELEASE;
                tmr_val = RD_LOAD;
              end else begin
                state_d = ST_ERROR;
                err_d   = ERR_CSUM;
                busy_d  = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q       <= ERR_NONE;
      len_lo_q    <= '0;
      len_q       <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ld_we_q     <= 1'b0;
      ld_addr_q   <= '0;
      ld_data_q   <= '0;
    end else begin
      err_q       <= err_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ld_we_q     <= ld_we_d;
      ld_addr_q   <= ld_addr_d;
      ld_data_q   <= ld_data_d;
    end
  end

  // The loader keeps the RAM one extra cycle after busy drops so a final
  // registered write is never lost to the CPU side.
  logic ld_own;
  assign ld_own = busy_q | ld_we_q;

  always_comb begin
    if (ld_own) begin
      bus.o_mem_addr  = ld_addr_q;
      bus.o_mem_wdata = ld_data_q;
      bus.o_mem_we    = ld_we_q;
    end else begin
      bus.o_mem_addr  = bus.i_cpu_addr;
      bus.o_mem_wdata = bus.i_cpu_wdata;
      bus.o_mem_we    = bus.i_cpu_we;
    end
  end

  assign bus.o_rx_ready = rx_ready;
  assign o_cpu_rst_n    = cpu_rst_n_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_err          = err_q;

endmodule
